// File: rtl/rgy_pkg.sv
// Shared types and helpers for the multi-approach traffic-light controller.
package rgy_pkg;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } rgy_state_e;

  // Width of the approach index; a single approach still needs one bit.
  function automatic int unsigned dir_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgy_phase_timer.sv
// Phase counter: counts up from zero, flags the last cycle of a phase.
module rgy_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // Restart on every phase entry, otherwise count up.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == limit);

endmodule

// File: rtl/rgy_multi_ctrl.sv
// Multi-approach traffic-light controller: round-robin green/yellow/all-red
// sequencing, latched pedestrian requests with walk lamps, flashing-yellow mode.
module rgy_multi_ctrl
  import rgy_pkg::*;
#(
  parameter int unsigned NUM_DIR     = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned GREEN_T     = 20,
  parameter int unsigned MIN_GREEN_T = 8,
  parameter int unsigned YELLOW_T    = 4,
  parameter int unsigned ALLRED_T    = 2,
  parameter int unsigned PED_T       = 10,
  parameter int unsigned FLASH_T     = 5,
  localparam int unsigned DIR_W      = dir_w(NUM_DIR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_DIR-1:0] ped_req,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] walk,
  output logic [DIR_W-1:0]   cur_dir
);

  localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] MIN_LIM    = CNT_W'(MIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LIM = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LIM  = CNT_W'(FLASH_T - 1);
  // One bit wider so PED_T == 2**CNT_W still compares correctly.
  localparam logic [CNT_W:0]   PED_CMP    = (CNT_W + 1)'(PED_T);
  localparam logic [DIR_W-1:0] LAST_DIR   = DIR_W'(NUM_DIR - 1);

  rgy_state_e         state_q, state_d;
  logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
  logic [NUM_DIR-1:0] ped_pend_q, ped_pend_d;
  logic               walk_on_q, walk_on_d;
  logic               flash_ph_q, flash_ph_d;

  logic [CNT_W-1:0]   cnt, limit;
  logic               done, clear, early, enter_green;
  logic [NUM_DIR-1:0] dir_oh, pend_now;

  rgy_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .limit(limit),
    .cnt  (cnt),
    .done (done)
  );

  // One-hot of the served approach.
  always_comb begin
    dir_oh = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      dir_oh[i] = (cur_dir_q == DIR_W'(i));
    end
  end

  // Phase length for the current state.
  always_comb begin
    limit = ALLRED_LIM;
    case (state_q)
      S_ALLRED: limit = ALLRED_LIM;
      S_GREEN:  limit = GREEN_LIM;
      S_YELLOW: limit = YELLOW_LIM;
      S_FLASH:  limit = FLASH_LIM;
      default:  limit = ALLRED_LIM;
    endcase
  end

  // Cut green short once the floor is met and another approach is waiting.
  assign early = (NUM_DIR > 1) && (cnt >= MIN_LIM) && (|(ped_pend_q & ~dir_oh));

  // State sequencing; en low overrides everything but reset.
  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    if (!en) begin
      state_d = S_FLASH;
    end else begin
      case (state_q)
        S_ALLRED: if (done) state_d = S_GREEN;
        S_GREEN:  if (done || early) state_d = S_YELLOW;
        S_YELLOW: begin
          if (done) begin
            state_d   = S_ALLRED;
            cur_dir_d = (cur_dir_q == LAST_DIR) ? '0 : cur_dir_q + DIR_W'(1);
          end
        end
        S_FLASH: begin
          state_d   = S_ALLRED;
          cur_dir_d = '0;
        end
        default: state_d = S_ALLRED;
      endcase
    end
  end

  assign enter_green = (state_d == S_GREEN) && (state_q != S_GREEN);
  // Flash keeps its own state but restarts the counter every half-period.
  assign clear = (state_d != state_q) || ((state_q == S_FLASH) && done);
  assign pend_now = ped_pend_q | ped_req;

  // Pedestrian latches and walk grant, plus the flash phase toggle.
  always_comb begin
    ped_pend_d = pend_now;
    walk_on_d  = walk_on_q;
    flash_ph_d = flash_ph_q;
    if (!en) begin
      ped_pend_d = '0;
      walk_on_d  = 1'b0;
    end else if (enter_green) begin
      walk_on_d  = |(pend_now & dir_oh);
      ped_pend_d = pend_now & ~dir_oh;
    end
    if (state_q != S_FLASH) begin
      flash_ph_d = 1'b1;
    end else if (done) begin
      flash_ph_d = ~flash_ph_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ALLRED;
      cur_dir_q  <= '0;
      ped_pend_q <= '0;
      walk_on_q  <= 1'b0;
      flash_ph_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      ped_pend_q <= ped_pend_d;
      walk_on_q  <= walk_on_d;
      flash_ph_q <= flash_ph_d;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '1;
    walk   = '0;
    case (state_q)
      S_GREEN: begin
        green = dir_oh;
        red   = ~dir_oh;
        if (walk_on_q && ({1'b0, cnt} < PED_CMP)) walk = dir_oh;
      end
      S_YELLOW: begin
        yellow = dir_oh;
        red    = ~dir_oh;
      end
      S_FLASH: begin
        yellow = {NUM_DIR{flash_ph_q}};
        red    = '0;
      end
      default: red = '1;
    endcase
  end

  assign cur_dir = cur_dir_q;

endmodule

// File: tb/tb_rgy_multi_ctrl.sv
// Scoreboard bench for rgy_multi_ctrl with three approaches and default timings.
module tb_rgy_multi_ctrl;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] y;
    logic [2:0] r;
    logic [2:0] w;
    logic [1:0] dir;
  } lamps_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [2:0] ped_req = 3'b000;
  logic [2:0] green, yellow, red, walk;
  logic [1:0] cur_dir;

  lamps_t sbq[$];
  int     checks = 0;
  int     fails = 0;

  always #5 clk = ~clk;

  rgy_multi_ctrl #(
    .NUM_DIR(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .ped_req(ped_req),
    .green  (green),
    .yellow (yellow),
    .red    (red),
    .walk   (walk),
    .cur_dir(cur_dir)
  );

  function automatic logic [2:0] oh(input logic [1:0] d);
    logic [2:0] one;
    one = 3'b001;
    return one << d;
  endfunction

  task automatic push(input logic [2:0] g, input logic [2:0] y, input logic [2:0] r,
                      input logic [2:0] w, input logic [1:0] d, input int n);
    lamps_t e;
    e.g = g; e.y = y; e.r = r; e.w = w; e.dir = d;
    repeat (n) sbq.push_back(e);
  endtask

  task automatic push_green(input logic [1:0] d, input int n, input bit wk);
    push(oh(d), 3'b000, ~oh(d), wk ? oh(d) : 3'b000, d, n);
  endtask

  task automatic push_yellow(input logic [1:0] d, input int n);
    push(3'b000, oh(d), ~oh(d), 3'b000, d, n);
  endtask

  task automatic push_allred(input logic [1:0] d, input int n);
    push(3'b000, 3'b000, 3'b111, 3'b000, d, n);
  endtask

  task automatic push_flash(input logic [1:0] d, input bit ph, input int n);
    push(3'b000, {3{ph}}, 3'b000, 3'b000, d, n);
  endtask

  // Advance to the falling edge, pop the expected lamps, sample the DUT.
  task automatic tick(output lamps_t exp_v, output lamps_t obs);
    @(negedge clk);
    if (sbq.size() == 0) exp_v = 'x;
    else exp_v = sbq.pop_front();
    obs.g = green; obs.y = yellow; obs.r = red; obs.w = walk; obs.dir = cur_dir;
  endtask

  // Two reset cycles, then the first full approach and entry into approach 1.
  task automatic test_reset;
    lamps_t e, o;
    int k;
    push_allred(0, 3);
    push_green(0, 20, 0);
    push_yellow(0, 4);
    push_allred(1, 2);
    push_green(1, 1, 0);
    k = 0;
    while (sbq.size() > 0) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_seq cyc %0d: got g=%b y=%b r=%b w=%b dir=%0d want g=%b y=%b r=%b w=%b dir=%0d",
                 k, o.g, o.y, o.r, o.w, o.dir, e.g, e.y, e.r, e.w, e.dir);
      end
      if (k == 1) reset = 1'b0;
      k++;
    end
  endtask

  // Remaining rotation through approaches 1 and 2 back to approach 0.
  task automatic test_wrap;
    lamps_t e, o;
    int k;
    push_green(1, 19, 0);
    push_yellow(1, 4);
    push_allred(2, 2);
    push_green(2, 20, 0);
    push_yellow(2, 4);
    push_allred(0, 2);
    push_green(0, 1, 0);
    k = 0;
    while (sbq.size() > 0) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL wrap cyc %0d: got g=%b y=%b r=%b w=%b dir=%0d want g=%b y=%b r=%b w=%b dir=%0d",
                 k, o.g, o.y, o.r, o.w, o.dir, e.g, e.y, e.r, e.w, e.dir);
      end
      k++;
    end
  endtask

  // Request for approach 1 at cnt=10 of approach-0 green.
  task automatic test_ped;
    lamps_t e, o;
    int k;
    push_green(0, 11, 0);
    push_yellow(0, 4);
    push_allred(1, 2);
    push_green(1, 10, 1);
    push_green(1, 10, 0);
    push_yellow(1, 4);
    push_allred(2, 2);
    push_green(2, 20, 0);  // full length: no stale request for approach 1
    push_yellow(2, 4);
    push_allred(0, 2);
    push_green(0, 1, 0);
    k = 0;
    while (sbq.size() > 0) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL ped cyc %0d: got g=%b y=%b r=%b w=%b dir=%0d want g=%b y=%b r=%b w=%b dir=%0d",
                 k, o.g, o.y, o.r, o.w, o.dir, e.g, e.y, e.r, e.w, e.dir);
      end
      if (k == 9) ped_req = 3'b010;
      if (k == 10) ped_req = 3'b000;
      k++;
    end
  endtask

  // Request for approach 2 at cnt=2: greens of 0 and 1 are cut to the 8-cycle floor.
  task automatic test_floor;
    lamps_t e, o;
    int k;
    push_green(0, 7, 0);
    push_yellow(0, 4);
    push_allred(1, 2);
    push_green(1, 8, 0);
    push_yellow(1, 4);
    push_allred(2, 2);
    push_green(2, 10, 1);
    push_green(2, 10, 0);
    push_yellow(2, 2);
    k = 0;
    while (sbq.size() > 0) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL floor cyc %0d: got g=%b y=%b r=%b w=%b dir=%0d want g=%b y=%b r=%b w=%b dir=%0d",
                 k, o.g, o.y, o.r, o.w, o.dir, e.g, e.y, e.r, e.w, e.dir);
      end
      if (k == 1) ped_req = 3'b100;
      if (k == 2) ped_req = 3'b000;
      k++;
    end
  endtask

  // Drop en mid-yellow, one full flash period, then resume at approach 0.
  task automatic test_flash;
    lamps_t e, o;
    int k;
    en = 1'b0;
    push_flash(2, 1'b1, 5);
    push_flash(2, 1'b0, 5);
    push_allred(0, 2);
    push_green(0, 1, 0);
    k = 0;
    while (sbq.size() > 0) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL flash cyc %0d: got g=%b y=%b r=%b w=%b dir=%0d want g=%b y=%b r=%b w=%b dir=%0d",
                 k, o.g, o.y, o.r, o.w, o.dir, e.g, e.y, e.r, e.w, e.dir);
      end
      if (k == 9) en = 1'b1;
      k++;
    end
  endtask

  // Reset mid-green with approach 1 pending: the request must be forgotten.
  task automatic test_reset_mid;
    lamps_t e, o;
    int k;
    push_green(0, 5, 0);
    push_allred(0, 3);
    push_green(0, 20, 0);
    push_yellow(0, 4);
    push_allred(1, 2);
    push_green(1, 10, 0);
    k = 0;
    while (sbq.size() > 0) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid cyc %0d: got g=%b y=%b r=%b w=%b dir=%0d want g=%b y=%b r=%b w=%b dir=%0d",
                 k, o.g, o.y, o.r, o.w, o.dir, e.g, e.y, e.r, e.w, e.dir);
      end
      if (k == 2) ped_req = 3'b010;
      if (k == 3) ped_req = 3'b000;
      if (k == 4) reset = 1'b1;
      if (k == 6) reset = 1'b0;
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_ped();
    test_floor();
    test_flash();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
